ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage, directly downstream of the ID/EX pipeline register. It consumes the
//  latched aluop, alusel, operands, destination and write enable, and produces the EX/MEM
//  write-back result. Logic, shift and arithmetic ops are single-cycle combinational.
//  DIV and DIVU run on an iterative 32-step divider that holds the pipeline via stallreq_o.
// PARAMETERS
//  DIV_ZERO_Q   32'hFFFFFFFF   quotient (LO) returned when the divisor is 0
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  ex_aluop     in   8   op from ID/EX
//  ex_alusel    in   3   result class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH
//  ex_reg1      in   32  operand 1 (shift amount in [4:0]; dividend)
//  ex_reg2      in   32  operand 2 (shifted value; divisor)
//  ex_wd        in   32  destination register index, passed through
//  ex_wreg      in   1   GPR write enable from decode
//  ex_inst      in   32  instruction word, passed through
//  wd_o         out  32  = ex_wd
//  wreg_o       out  1   ex_wreg, forced 0 for DIV/DIVU
//  wdata_o      out  32  GPR result; 0 for NOP, DIV, DIVU and unknown ops
//  inst_o       out  32  = ex_inst
//  whilo_o      out  1   1 for one cycle when hi_o/lo_o hold a divide result
//  hi_o         out  32  remainder
//  lo_o         out  32  quotient
//  stallreq_o   out  1   request to freeze stages 0..2 and bubble EX/MEM
// BEHAVIOUR
//  aluop codes: NOP 00, AND 24, OR 25, XOR 26, NOR 27, SLL 7C, SRL 02, SRA 03,
//    ADD 20, SUB 22, SLT 2A, SLTU 2B, DIV 1A, DIVU 1B (hex).
//  Combinational path, zero latency:
//    SLL/SRL/SRA give reg2 shifted by reg1[4:0].
//    ADD/SUB wrap mod 2^32, no overflow trap.
//    SLT is signed compare; SLTU is unsigned compare. Each returns 32'd1 or 32'd0.
//  Reset (rst=0, async): divider FSM -> IDLE, counter, partial remainder and quotient
//    cleared; stallreq_o=0, whilo_o=0, hi_o=lo_o=0. Other outputs follow inputs.
//  Divider FSM states: IDLE, BUSY, DONE.
//    IDLE + DIV/DIVU: stallreq_o=1.
//      Divisor != 0: latch |operands| (DIV) or raw operands (DIVU), record sign flags,
//        cnt=0, go to BUSY.
//      Divisor == 0: go to DONE with lo=DIV_ZERO_Q and hi=reg1 (raw dividend).
//    BUSY: one restoring shift-subtract step per cycle; stallreq_o=1.
//      After the cnt=31 step, go to DONE.
//    DONE: stallreq_o=0, whilo_o=1, hi_o/lo_o valid. Always go to IDLE next edge.
//    Sign fix-up (DIV only): quotient is negated if the operand signs differ; remainder
//      takes the dividend's sign. 0x80000000 / -1 gives lo=0x80000000, hi=0.
//  Latency (divisor != 0): issue cycle + 32 BUSY + 1 DONE = 34 cycles in EX.
//    stallreq_o is high for exactly 33 consecutive cycles.
//  Outside DONE: whilo_o=0, and hi_o/lo_o hold their last value.
//  aluop leaves DIV/DIVU while BUSY (flush): abort to IDLE at next edge, stallreq_o=0
//    that cycle, no whilo_o pulse.
//  Reset asserted mid-division: immediate return to IDLE, stallreq_o drops
//    asynchronously, no result is produced.
//  Back-to-back DIVs: the second starts at the edge after DONE (DONE->IDLE, then issue).
// TESTING
//  1 ADD reg1=5 reg2=7 -> wdata_o=12, wreg_o=1, stallreq_o=0 same cycle;
//    SUB 3-5 -> 0xFFFFFFFE.
//  2 SRA reg1=4 reg2=0x80000000 -> 0xF8000000; SRL same operands -> 0x08000000;
//    SLT -1,1 -> 1; SLTU -1,1 -> 0.
//  3 DIVU 100/7 -> stallreq_o high 33 cycles, then one cycle whilo_o=1, lo=14, hi=2,
//    wreg_o=0.
//  4 DIV 0xFFFFFFF9 / 2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 DIVU 0x1234/0 -> stallreq_o high 1 cycle, next cycle whilo_o=1,
//    lo=0xFFFFFFFF, hi=0x1234.
//  6 Pull rst low at BUSY cnt=10 -> stallreq_o=0 immediately, no whilo_o pulse;
//    release reset, then DIVU 9/3 -> lo=3, hi=0 after full latency.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arithmetic results plus an iterative
// 32-step restoring divider (DIV/DIVU) that stalls the pipeline while it runs.
module ex_stage #(
   parameter logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ex_aluop,
   input  logic [2:0]  ex_alusel,
   input  logic [31:0] ex_reg1,
   input  logic [31:0] ex_reg2,
   input  logic [31:0] ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_inst,
   output logic [31:0] wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic [31:0] inst_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR = 8'h26, OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h20, OP_SUB  = 8'h22, OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_DIV  = 8'h1A, OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_div, a_neg, b_neg, stall_raw;
   logic [31:0] a_abs, b_abs, rem_step, quo_step;
   logic [32:0] part, diff;

   assign wd_o   = ex_wd;
   assign inst_o = ex_inst;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign is_div = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
   assign wreg_o = ex_wreg & ~is_div;

   always_comb begin
      wdata_o = '0;
      case (ex_alusel)
         3'd1: case (ex_aluop)
            OP_AND:  wdata_o = ex_reg1 & ex_reg2;
            OP_OR:   wdata_o = ex_reg1 | ex_reg2;
            OP_XOR:  wdata_o = ex_reg1 ^ ex_reg2;
            OP_NOR:  wdata_o = ~(ex_reg1 | ex_reg2);
            default: wdata_o = '0;
         endcase
         3'd2: case (ex_aluop)
            OP_SLL:  wdata_o = ex_reg2 << ex_reg1[4:0];
            OP_SRL:  wdata_o = ex_reg2 >> ex_reg1[4:0];
            OP_SRA:  wdata_o = $signed(ex_reg2) >>> ex_reg1[4:0];
            default: wdata_o = '0;
         endcase
         3'd3: case (ex_aluop)
            OP_ADD:  wdata_o = ex_reg1 + ex_reg2;
            OP_SUB:  wdata_o = ex_reg1 - ex_reg2;
            OP_SLT:  wdata_o = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
            OP_SLTU: wdata_o = {31'd0, ex_reg1 < ex_reg2};
            default: wdata_o = '0;
         endcase
         default: wdata_o = '0;
      endcase
   end

   // Signed divide runs on magnitudes; sign flags are applied when the result is stored.
   assign a_neg = (ex_aluop == OP_DIV) & ex_reg1[31];
   assign b_neg = (ex_aluop == OP_DIV) & ex_reg2[31];
   assign a_abs = a_neg ? -ex_reg1 : ex_reg1;
   assign b_abs = b_neg ? -ex_reg2 : ex_reg2;

   // One restoring step: the dividend's MSB shifts into the partial remainder.
   assign part     = {rem_q, quo_q[31]};
   assign diff     = part - {1'b0, dvs_q};
   assign rem_step = diff[32] ? part[31:0] : diff[31:0];
   assign quo_step = {quo_q[30:0], ~diff[32]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall_raw = 1'b0;
      whilo_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_div) begin
               stall_raw = 1'b1;
               if (ex_reg2 == '0) begin
                  lo_d    = DIV_ZERO_Q;
                  hi_d    = ex_reg1;
                  state_d = S_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = a_abs;
                  dvs_d   = b_abs;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (!is_div) begin
               state_d = S_IDLE;
            end else begin
               stall_raw = 1'b1;
               rem_d     = rem_step;
               quo_d     = quo_step;
               cnt_d     = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  lo_d    = negq_q ? -quo_step : quo_step;
                  hi_d    = negr_q ? -rem_step : rem_step;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            whilo_o = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Gated by reset so the stall request falls as soon as reset is asserted.
   assign stallreq_o = stall_raw & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected ALU and divide results,
// a negedge monitor pops and compares them when the DUT presents a result.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  ex_aluop = 8'h00;
   logic [2:0]  ex_alusel = 3'd0;
   logic [31:0] ex_reg1 = '0, ex_reg2 = '0, ex_wd = '0, ex_inst = '0;
   logic        ex_wreg = 1'b0;
   logic [31:0] wd_o, wdata_o, inst_o, hi_o, lo_o;
   logic        wreg_o, whilo_o, stallreq_o;

   ex_stage #(.DIV_ZERO_Q(32'hFFFFFFFF)) dut (
      .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_inst(ex_inst), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .inst_o(inst_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
      .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wdata;
      logic        wreg;
      logic [31:0] wd;
      logic [31:0] inst;
   } alu_exp_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall;
   } div_exp_t;

   alu_exp_t alu_q[$];
   div_exp_t div_q[$];
   int       checks = 0;
   int       errors = 0;
   logic     alu_vld = 1'b0;
   int       stall_run = 0;

   localparam logic [7:0] OPS [15] = '{8'h00, 8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02,
                                       8'h03, 8'h20, 8'h22, 8'h2A, 8'h2B, 8'h55, 8'h20, 8'h2A};

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] sel_of(input logic [7:0] op);
      case (op)
         8'h00:                      return 3'd0;
         8'h24, 8'h25, 8'h26, 8'h27: return 3'd1;
         8'h7C, 8'h02, 8'h03:        return 3'd2;
         default:                    return 3'd3;
      endcase
   endfunction

   function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      int unsigned sh;
      longint      v, p, r;
      logic [63:0] prod;
      sh = a[4:0];
      p  = longint'(1) << sh;
      case (op)
         8'h24: return a & b;
         8'h25: return a | b;
         8'h26: return a ^ b;
         8'h27: return ~(a | b);
         8'h7C: begin prod = {32'd0, b} * p; return prod[31:0]; end
         8'h02: return b / p;
         8'h03: begin
            v = longint'($signed(b));
            r = (v >= 0) ? v / p : -((-v + p - 1) / p);
            return r[31:0];
         end
         8'h20: return a + b;
         8'h22: return a - b;
         8'h2A: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         8'h2B: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic div_exp_t div_model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
      div_exp_t e;
      longint   sa, sb, q, r;
      if (b == 0) begin
         e.lo = 32'hFFFFFFFF; e.hi = a; e.stall = 1;
      end else begin
         sa = sgn ? longint'($signed(a)) : longint'(a);
         sb = sgn ? longint'($signed(b)) : longint'(b);
         q  = sa / sb;
         r  = sa % sb;
         e.lo = q[31:0]; e.hi = r[31:0]; e.stall = 33;
      end
      return e;
   endfunction

   task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      ex_aluop  = op;
      ex_alusel = sel_of(op);
      ex_reg1   = a;
      ex_reg2   = b;
      ex_wd     = $urandom;
      ex_wreg   = 1'($urandom);
      ex_inst   = $urandom;
   endtask

   task automatic do_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_exp_t e;
      drive(op, a, b);
      e.wdata = alu_model(op, a, b);
      e.wreg  = ex_wreg;
      e.wd    = ex_wd;
      e.inst  = ex_inst;
      alu_q.push_back(e);
      alu_vld = 1'b1;
      @(negedge clk);
      #1;
      alu_vld = 1'b0;
   endtask

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic got;
      drive(sgn ? 8'h1A : 8'h1B, a, b);
      div_q.push_back(div_model(sgn, a, b));
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (whilo_o) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL div_timeout: got no whilo_o within 40 cycles, required one pulse");
         if (div_q.size() > 0) void'(div_q.pop_front());
      end
   endtask

   // Monitor: consumes expected results only when the DUT presents them.
   initial begin
      alu_exp_t ea;
      div_exp_t ed;
      forever begin
         @(negedge clk);
         if (alu_vld) begin
            if (alu_q.size() == 0) begin
               check32("alu_queue_empty", 32'd0, 32'd1);
            end else begin
               ea = alu_q.pop_front();
               check32("wdata", wdata_o, ea.wdata);
               check32("wreg", {31'd0, wreg_o}, {31'd0, ea.wreg});
               check32("wd_pass", wd_o, ea.wd);
               check32("inst_pass", inst_o, ea.inst);
               check32("alu_stall", {31'd0, stallreq_o}, 32'd0);
            end
         end
         if (whilo_o) begin
            if (div_q.size() == 0) begin
               check32("unexpected_whilo", 32'd1, 32'd0);
            end else begin
               ed = div_q.pop_front();
               check32("div_lo", lo_o, ed.lo);
               check32("div_hi", hi_o, ed.hi);
               check32("div_wreg", {31'd0, wreg_o}, 32'd0);
               check32("div_stall_cycles", stall_run, ed.stall);
            end
            stall_run = 0;
         end else if (stallreq_o) begin
            stall_run++;
         end else begin
            stall_run = 0;
         end
      end
   end

   initial begin
      int          k;
      logic [31:0] a, b;
      // Reset state, with a divide op presented while reset is held.
      ex_aluop  = 8'h1B;
      ex_alusel = 3'd3;
      ex_reg1   = 32'd10;
      ex_reg2   = 32'd3;
      repeat (3) @(negedge clk);
      check32("rst_stall", {31'd0, stallreq_o}, 32'd0);
      check32("rst_whilo", {31'd0, whilo_o}, 32'd0);
      check32("rst_hi", hi_o, 32'd0);
      check32("rst_lo", lo_o, 32'd0);
      ex_aluop  = 8'h00;
      ex_alusel = 3'd0;
      rst       = 1'b1;

      do_alu(8'h20, 32'd5, 32'd7);
      do_alu(8'h22, 32'd3, 32'd5);
      do_alu(8'h03, 32'd4, 32'h80000000);
      do_alu(8'h02, 32'd4, 32'h80000000);
      do_alu(8'h2A, 32'hFFFFFFFF, 32'd1);
      do_alu(8'h2B, 32'hFFFFFFFF, 32'd1);
      do_alu(8'h7C, 32'd31, 32'h00000003);

      do_div(1'b0, 32'd100, 32'd7);
      do_div(1'b1, 32'hFFFFFFF9, 32'd2);
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
      do_div(1'b0, 32'h1234, 32'd0);
      do_div(1'b1, 32'hFFFFFF00, 32'd0);
      do_div(1'b0, 32'hFFFFFFFF, 32'd1);

      // Flush: leave DIV while busy, no result may appear.
      drive(8'h1A, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      do_alu(8'h20, 32'h7FFFFFFF, 32'd1);
      repeat (4) @(posedge clk);

      // Reset in the middle of a division (BUSY with cnt=10).
      drive(8'h1B, 32'd50, 32'd5);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check32("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
      check32("rst_mid_hi", hi_o, 32'd0);
      check32("rst_mid_lo", lo_o, 32'd0);
      ex_aluop  = 8'h00;
      ex_alusel = 3'd0;
      @(negedge clk);
      rst = 1'b1;
      do_div(1'b0, 32'd9, 32'd3);

      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 99) < 15) begin
            if ($urandom_range(0, 5) == 0) b = '0;
            else if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 30);
            do_div(1'($urandom), a, b);
         end else begin
            k = $urandom_range(0, 14);
            do_alu(OPS[k], a, b);
         end
      end

      drive(8'h00, '0, '0);
      repeat (3) @(posedge clk);
      check32("alu_q_drained", alu_q.size(), 32'd0);
      check32("div_q_drained", div_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
